// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with Z/N flags, branch resolution and wrong-path squash.
// Accepted EX instructions appear on the q_ outputs one cycle later. A taken
// branch raises a one-cycle redirect pulse. The next SQUASH_DEPTH valid
// instructions are then turned into bubbles.
module ex_mem_reg #(
    parameter int SQUASH_DEPTH = 2,
    parameter int RD_W         = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [31:0]     alu_out,
    input  logic            alu_z,
    input  logic            alu_n,
    input  logic [31:0]     rt_data,
    input  logic [RD_W-1:0] rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            flag_write,
    input  logic            br_z,
    input  logic            br_n,
    input  logic            jump,
    input  logic [31:0]     target,
    output logic            q_valid,
    output logic            q_reg_write,
    output logic            q_mem_read,
    output logic            q_mem_write,
    output logic            q_mem_to_reg,
    output logic [31:0]     q_alu_out,
    output logic [31:0]     q_rt_data,
    output logic [RD_W-1:0] q_rd,
    output logic            z_flag,
    output logic            n_flag,
    output logic            take_branch,
    output logic [31:0]     q_target
);

    typedef enum logic {RUN, SQUASH} state_t;

    // Squash depth is 1..3, so a 2-bit down-counter is enough.
    localparam logic [1:0] DEPTH = SQUASH_DEPTH[1:0];

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       accept;
    logic       branch_cond;
    logic       taken;

    // Acceptance, branch decision on the stored flags, and FSM next state.
    always_comb begin
        accept      = in_valid & ~stall & ~flush & (state_reg == RUN);
        branch_cond = jump | (br_z & z_flag) | (br_n & n_flag);
        taken       = accept & branch_cond;
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        if (flush) begin
            state_next = RUN;
            cnt_next   = 2'd0;
        end else if (!stall) begin
            case (state_reg)
                RUN: begin
                    if (taken) begin
                        state_next = SQUASH;
                        cnt_next   = DEPTH;
                    end
                end
                SQUASH: begin
                    // Only real wrong-path instructions use up the squash budget.
                    if (in_valid) begin
                        cnt_next = cnt_reg - 2'd1;
                        if (cnt_reg == 2'd1) begin
                            state_next = RUN;
                        end
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 2'd0;
                end
            endcase
        end
    end

    // FSM state and squash counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Valid, control bits and the redirect pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid      <= 1'b0;
            q_reg_write  <= 1'b0;
            q_mem_read   <= 1'b0;
            q_mem_write  <= 1'b0;
            q_mem_to_reg <= 1'b0;
            take_branch  <= 1'b0;
            q_target     <= 32'd0;
        end else if (flush) begin
            q_valid      <= 1'b0;
            q_reg_write  <= 1'b0;
            q_mem_read   <= 1'b0;
            q_mem_write  <= 1'b0;
            q_mem_to_reg <= 1'b0;
            take_branch  <= 1'b0;
        end else if (!stall) begin
            q_valid      <= accept;
            q_reg_write  <= accept & reg_write;
            q_mem_read   <= accept & mem_read;
            q_mem_write  <= accept & mem_write;
            q_mem_to_reg <= accept & mem_to_reg;
            take_branch  <= taken;
            if (taken) begin
                q_target <= target;
            end
        end else begin
            // A stalled cycle never redirects, even right after a taken branch.
            take_branch <= 1'b0;
        end
    end

    // Data payload only loads on acceptance. Bubbles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_alu_out <= 32'd0;
            q_rt_data <= 32'd0;
            q_rd      <= '0;
        end else if (accept) begin
            q_alu_out <= alu_out;
            q_rt_data <= rt_data;
            q_rd      <= rd;
        end
    end

    // Architectural flags, written only by accepted flag-setting instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_flag <= 1'b0;
            n_flag <= 1'b0;
        end else if (accept && flag_write) begin
            z_flag <= alu_z;
            n_flag <= alu_n;
        end
    end

endmodule
